// File: rtl/gravsim_pkg.sv
// Shared types for the gravity simulator: Q16.16 state words and the integrator FSM encoding.
package gravsim_pkg;

    typedef logic signed [31:0] q16_16_t;

    localparam int unsigned FracBits = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StCalc,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/euler_integrator_if.sv
// Link between the integrator and the force stage: acceleration fetch and position write-back.
interface euler_integrator_if #(
    parameter int unsigned m10k_address_len = 12
) ();
    import gravsim_pkg::*;

    logic [m10k_address_len-1:0] accel_addr;
    q16_16_t                     x_accel_in;
    q16_16_t                     y_accel_in;
    logic [m10k_address_len-1:0] pos_write_addr;
    logic                        pos_we;
    q16_16_t                     x_pos_out;
    q16_16_t                     y_pos_out;
    q16_16_t                     mass_out;

    modport master (
        output accel_addr, pos_write_addr, pos_we, x_pos_out, y_pos_out, mass_out,
        input  x_accel_in, y_accel_in
    );

    modport slave (
        input  accel_addr, pos_write_addr, pos_we, x_pos_out, y_pos_out, mass_out,
        output x_accel_in, y_accel_in
    );
endinterface

// File: rtl/m10k_ram.sv
// Simple dual-port RAM with a registered read; a same-address write returns the old word.
module m10k_ram #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4096,
    parameter int unsigned AddrW = 12
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/euler_integrator.sv
// Semi-implicit Euler integrator: one object per 4 cycles (read, wait, calc, write).
module euler_integrator
    import gravsim_pkg::*;
#(
    parameter int unsigned max_size         = 4096,
    parameter int unsigned m10k_address_len = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [m10k_address_len-1:0] num_objects,
    input  logic [4:0]                  dt_shift,
    input  logic [m10k_address_len-1:0] hps_addr,
    input  logic                        hps_we,
    input  q16_16_t                     hps_x,
    input  q16_16_t                     hps_y,
    input  q16_16_t                     hps_vx,
    input  q16_16_t                     hps_vy,
    input  q16_16_t                     hps_mass,
    input  logic [m10k_address_len-1:0] hps_read_addr,
    output q16_16_t                     hps_x_out,
    output q16_16_t                     hps_y_out,
    euler_integrator_if.master          fs,
    output logic                        busy,
    output logic                        done
);
    typedef logic [m10k_address_len-1:0] addr_t;

    state_e  state_q, state_d;
    addr_t   i_q, i_d, num_q, num_d;
    addr_t   accel_addr_q, accel_addr_d, pos_write_addr_q, pos_write_addr_d;
    logic    pos_we_q, pos_we_d, done_q, done_d;
    q16_16_t ax_q, ax_d, ay_q, ay_d, x_q, x_d, y_q, y_d;
    q16_16_t vx_q, vx_d, vy_q, vy_d, mass_q, mass_d;
    q16_16_t vx_new_q, vx_new_d, vy_new_q, vy_new_d;
    q16_16_t x_pos_q, x_pos_d, y_pos_q, y_pos_d, mass_out_q, mass_out_d;

    q16_16_t x_rd, y_rd, vx_rd, vy_rd, mass_rd;
    q16_16_t vx_next, vy_next, x_next, y_next;
    q16_16_t wx, wy, wvx, wvy;
    logic    st_we, mass_we;
    addr_t   st_waddr;

    // Velocity first, then position from the new velocity.
    assign vx_next = vx_q + (ax_q >>> dt_shift);
    assign vy_next = vy_q + (ay_q >>> dt_shift);
    assign x_next  = x_q + (vx_next >>> dt_shift);
    assign y_next  = y_q + (vy_next >>> dt_shift);

    always_comb begin
        st_we    = 1'b0;
        mass_we  = 1'b0;
        st_waddr = hps_addr;
        wx       = hps_x;
        wy       = hps_y;
        wvx      = hps_vx;
        wvy      = hps_vy;
        if (state_q == StIdle && hps_we) begin
            st_we   = 1'b1;
            mass_we = 1'b1;
        end else if (state_q == StWrite) begin
            st_we    = 1'b1;
            st_waddr = i_q;
            wx       = x_pos_q;
            wy       = y_pos_q;
            wvx      = vx_new_q;
            wvy      = vy_new_q;
        end
    end

    always_comb begin
        state_d          = state_q;
        i_d              = i_q;
        num_d            = num_q;
        accel_addr_d     = accel_addr_q;
        pos_write_addr_d = pos_write_addr_q;
        pos_we_d         = 1'b0;
        done_d           = 1'b0;
        ax_d             = ax_q;
        ay_d             = ay_q;
        x_d              = x_q;
        y_d              = y_q;
        vx_d             = vx_q;
        vy_d             = vy_q;
        mass_d           = mass_q;
        vx_new_d         = vx_new_q;
        vy_new_d         = vy_new_q;
        x_pos_d          = x_pos_q;
        y_pos_d          = y_pos_q;
        mass_out_d       = mass_out_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d = num_objects;
                    i_d   = '0;
                    if (num_objects != '0) begin
                        accel_addr_d = '0;
                        state_d      = StRead;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                ax_d    = fs.x_accel_in;
                ay_d    = fs.y_accel_in;
                x_d     = x_rd;
                y_d     = y_rd;
                vx_d    = vx_rd;
                vy_d    = vy_rd;
                mass_d  = mass_rd;
                state_d = StCalc;
            end
            // Outputs are registered here so they are valid throughout WRITE.
            StCalc: begin
                vx_new_d         = vx_next;
                vy_new_d         = vy_next;
                x_pos_d          = x_next;
                y_pos_d          = y_next;
                mass_out_d       = mass_q;
                pos_we_d         = 1'b1;
                pos_write_addr_d = i_q;
                state_d          = StWrite;
            end
            StWrite: begin
                if (i_q == num_q - addr_t'(1)) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    i_d          = i_q + addr_t'(1);
                    accel_addr_d = i_q + addr_t'(1);
                    state_d      = StRead;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            i_q              <= '0;
            num_q            <= '0;
            accel_addr_q     <= '0;
            pos_write_addr_q <= '0;
            pos_we_q         <= 1'b0;
            done_q           <= 1'b0;
            ax_q             <= '0;
            ay_q             <= '0;
            x_q              <= '0;
            y_q              <= '0;
            vx_q             <= '0;
            vy_q             <= '0;
            mass_q           <= '0;
            vx_new_q         <= '0;
            vy_new_q         <= '0;
            x_pos_q          <= '0;
            y_pos_q          <= '0;
            mass_out_q       <= '0;
        end else begin
            state_q          <= state_d;
            i_q              <= i_d;
            num_q            <= num_d;
            accel_addr_q     <= accel_addr_d;
            pos_write_addr_q <= pos_write_addr_d;
            pos_we_q         <= pos_we_d;
            done_q           <= done_d;
            ax_q             <= ax_d;
            ay_q             <= ay_d;
            x_q              <= x_d;
            y_q              <= y_d;
            vx_q             <= vx_d;
            vy_q             <= vy_d;
            mass_q           <= mass_d;
            vx_new_q         <= vx_new_d;
            vy_new_q         <= vy_new_d;
            x_pos_q          <= x_pos_d;
            y_pos_q          <= y_pos_d;
            mass_out_q       <= mass_out_d;
        end
    end

    // x and y keep a mirror copy so HPS readback never contends with the step's read port.
    m10k_ram #(.Width(32), .Depth(max_size), .AddrW(m10k_address_len)) u_x_ram (
        .clk_i(clk), .we_i(st_we), .waddr_i(st_waddr), .wdata_i(wx), .raddr_i(i_q), .rdata_o(x_rd)
    );
    m10k_ram #(.Width(32), .Depth(max_size), .AddrW(m10k_address_len)) u_y_ram (
        .clk_i(clk), .we_i(st_we), .waddr_i(st_waddr), .wdata_i(wy), .raddr_i(i_q), .rdata_o(y_rd)
    );
    m10k_ram #(.Width(32), .Depth(max_size), .AddrW(m10k_address_len)) u_vx_ram (
        .clk_i(clk), .we_i(st_we), .waddr_i(st_waddr), .wdata_i(wvx), .raddr_i(i_q),
        .rdata_o(vx_rd)
    );
    m10k_ram #(.Width(32), .Depth(max_size), .AddrW(m10k_address_len)) u_vy_ram (
        .clk_i(clk), .we_i(st_we), .waddr_i(st_waddr), .wdata_i(wvy), .raddr_i(i_q),
        .rdata_o(vy_rd)
    );
    m10k_ram #(.Width(32), .Depth(max_size), .AddrW(m10k_address_len)) u_mass_ram (
        .clk_i(clk), .we_i(mass_we), .waddr_i(hps_addr), .wdata_i(hps_mass), .raddr_i(i_q),
        .rdata_o(mass_rd)
    );
    m10k_ram #(.Width(32), .Depth(max_size), .AddrW(m10k_address_len)) u_x_rb_ram (
        .clk_i(clk), .we_i(st_we), .waddr_i(st_waddr), .wdata_i(wx), .raddr_i(hps_read_addr),
        .rdata_o(hps_x_out)
    );
    m10k_ram #(.Width(32), .Depth(max_size), .AddrW(m10k_address_len)) u_y_rb_ram (
        .clk_i(clk), .we_i(st_we), .waddr_i(st_waddr), .wdata_i(wy), .raddr_i(hps_read_addr),
        .rdata_o(hps_y_out)
    );

    assign fs.accel_addr     = accel_addr_q;
    assign fs.pos_write_addr = pos_write_addr_q;
    assign fs.pos_we         = pos_we_q;
    assign fs.x_pos_out      = x_pos_q;
    assign fs.y_pos_out      = y_pos_q;
    assign fs.mass_out       = mass_out_q;
    assign busy              = (state_q != StIdle);
    assign done              = done_q;
endmodule

// File: tb/tb_euler_integrator.sv
// Directed and randomized checks of euler_integrator against an array-based Euler model.
module tb_euler_integrator;
    logic        clk = 1'b0;
    logic        reset, start, hps_we, busy, done;
    logic [11:0] num_objects, hps_addr, hps_read_addr;
    logic [4:0]  dt_shift;
    logic [31:0] hps_x, hps_y, hps_vx, hps_vy, hps_mass, hps_x_out, hps_y_out;

    int n_checks = 0;
    int n_errors = 0;
    int mx[8], my[8], mvx[8], mvy[8], mm[8], ax_mem[8], ay_mem[8];
    int last_x;

    euler_integrator_if #(.m10k_address_len(12)) fs ();

    euler_integrator #(.max_size(4096), .m10k_address_len(12)) dut (
        .clk(clk), .reset(reset), .start(start), .num_objects(num_objects),
        .dt_shift(dt_shift), .hps_addr(hps_addr), .hps_we(hps_we), .hps_x(hps_x),
        .hps_y(hps_y), .hps_vx(hps_vx), .hps_vy(hps_vy), .hps_mass(hps_mass),
        .hps_read_addr(hps_read_addr), .hps_x_out(hps_x_out), .hps_y_out(hps_y_out),
        .fs(fs), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Force-stage stand-in: acceleration data follows accel_addr by one cycle.
    task automatic tick();
        logic [11:0] prev;
        prev = fs.accel_addr;
        @(posedge clk);
        #1;
        fs.x_accel_in = ax_mem[prev[2:0]];
        fs.y_accel_in = ay_mem[prev[2:0]];
    endtask

    task automatic load(input int j, input int x, input int y, input int vx, input int vy,
                        input int m);
        hps_addr = 12'(j); hps_x = x; hps_y = y; hps_vx = vx; hps_vy = vy; hps_mass = m;
        hps_we = 1'b1;
        tick();
        hps_we = 1'b0;
        mx[j] = x; my[j] = y; mvx[j] = vx; mvy[j] = vy; mm[j] = m;
    endtask

    task automatic load_random(input int n);
        for (int j = 0; j < n; j++) begin
            load(j, int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                 int'($urandom));
            ax_mem[j] = int'($urandom);
            ay_mem[j] = int'($urandom);
        end
    endtask

    task automatic check_readback(input int n);
        for (int j = 0; j < n; j++) begin
            hps_read_addr = 12'(j);
            tick();
            check($sformatf("rb_x[%0d]", j), hps_x_out, mx[j]);
            check($sformatf("rb_y[%0d]", j), hps_y_out, my[j]);
        end
    endtask

    // rst_at != 0 asserts reset after that sample; inject pulses start/hps_we mid-step.
    task automatic run_step(input int n, input int dts, input bit inject, input int rst_at);
        int nx[8], ny[8], nvx[8], nvy[8];
        int writes, dones, busy_cnt, pend_j;
        for (int j = 0; j < n; j++) begin
            nvx[j] = mvx[j] + (ax_mem[j] >>> dts);
            nvy[j] = mvy[j] + (ay_mem[j] >>> dts);
            nx[j]  = mx[j] + (nvx[j] >>> dts);
            ny[j]  = my[j] + (nvy[j] >>> dts);
        end
        writes = 0; dones = 0; busy_cnt = 0; pend_j = -1;
        num_objects = 12'(n);
        dt_shift = 5'(dts);
        start = 1'b1;
        for (int k = 1; k <= 4 * n + 8; k++) begin
            tick();
            if (k == 1) begin
                start = 1'b0;
                num_objects = 12'($urandom);
            end
            if (reset) begin
                check("rst_busy", {31'b0, busy}, 32'd0);
                check("rst_pos_we", {31'b0, fs.pos_we}, 32'd0);
                reset = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (pend_j >= 0) begin
                    check("rb_old_x", hps_x_out, mx[pend_j]);
                    check("rb_old_y", hps_y_out, my[pend_j]);
                    pend_j = -1;
                end
                if (fs.pos_we) begin
                    check("we_time", k, 4 * (writes + 1));
                    check("we_addr", {20'b0, fs.pos_write_addr}, writes);
                    check("x_pos", fs.x_pos_out, nx[writes]);
                    check("y_pos", fs.y_pos_out, ny[writes]);
                    check("mass", fs.mass_out, mm[writes]);
                    last_x = fs.x_pos_out;
                    pend_j = writes;
                    writes++;
                end
                if (done) begin
                    check("done_time", k, 4 * n + 1);
                    dones++;
                end
            end
            if (inject && k == 6) begin
                start = 1'b1; hps_we = 1'b1; hps_addr = 12'd1;
                hps_x = $urandom; hps_y = $urandom; hps_vx = $urandom; hps_vy = $urandom;
            end
            if (inject && k == 7) begin
                start = 1'b0; hps_we = 1'b0;
            end
            if (k == rst_at) reset = 1'b1;
            hps_read_addr = fs.accel_addr;
        end
        if (rst_at == 0) begin
            check("writes", writes, n);
            check("dones", dones, 1);
            check("busy_cycles", busy_cnt, 4 * n + 1);
        end else begin
            check("dones_after_reset", dones, 0);
        end
        for (int j = 0; j < n; j++) begin
            if (rst_at == 0 || 4 * (j + 1) < rst_at) begin
                mx[j] = nx[j]; my[j] = ny[j]; mvx[j] = nvx[j]; mvy[j] = nvy[j];
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hps_we = 1'b0; num_objects = '0; dt_shift = '0;
        hps_addr = '0; hps_read_addr = '0; hps_x = '0; hps_y = '0; hps_vx = '0; hps_vy = '0;
        hps_mass = '0; fs.x_accel_in = '0; fs.y_accel_in = '0;
        for (int j = 0; j < 8; j++) begin
            ax_mem[j] = 0; ay_mem[j] = 0;
        end
        tick();
        tick();
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_pos_we", {31'b0, fs.pos_we}, 32'd0);
        check("reset_accel_addr", {20'b0, fs.accel_addr}, 32'd0);
        check("reset_pos_write_addr", {20'b0, fs.pos_write_addr}, 32'd0);
        check("reset_x_pos_out", fs.x_pos_out, 32'd0);
        check("reset_y_pos_out", fs.y_pos_out, 32'd0);
        check("reset_mass_out", fs.mass_out, 32'd0);
        reset = 1'b0;
        tick();

        // Unit acceleration from rest, then a coast step exposing the stored velocity.
        load(0, 0, int'($urandom), 0, int'($urandom), int'($urandom));
        ax_mem[0] = 32'h0001_0000;
        ay_mem[0] = int'($urandom);
        run_step(1, 4, 1'b0, 0);
        check("first_x", last_x, 32'h0000_0100);
        ax_mem[0] = 0;
        run_step(1, 4, 1'b0, 0);
        check("coast_x", last_x, 32'h0000_0200);
        check_readback(1);

        load_random(3);
        run_step(3, int'($urandom_range(0, 20)), 1'b0, 0);
        check_readback(3);

        load(0, 32'h7FFF_FF00, 0, 32'h0010_0000, 0, 7);
        ax_mem[0] = 0; ay_mem[0] = 0;
        run_step(1, 0, 1'b0, 0);
        check("wrap_x", last_x, 32'h800F_FF00);

        load_random(3);
        run_step(3, int'($urandom_range(0, 12)), 1'b1, 0);
        check_readback(3);

        load_random(4);
        run_step(4, int'($urandom_range(0, 12)), 1'b0, 6);
        check_readback(4);

        run_step(0, 3, 1'b0, 0);

        load_random(5);
        run_step(5, int'($urandom_range(0, 31)), 1'b0, 0);
        check_readback(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/euler_integrator.md
EULER_INTEGRATOR -- requirements
Module: euler_integrator

Interface
REQ-001 SHALL have parameter max_size, default 4096, meaning the object capacity.
REQ-002 SHALL have parameter m10k_address_len, default 12, meaning the object index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse requesting one integration step, driven from the force stage's done.
REQ-006 SHALL have port num_objects, input, m10k_address_len bits: the count of active objects.
REQ-007 SHALL have port dt_shift, input, 5 bits: the timestep expressed as a right-shift amount.
REQ-008 SHALL have ports hps_addr, input, m10k_address_len bits, and hps_we, input, 1 bit: the HPS initial-state load port.
REQ-009 SHALL have ports hps_x, hps_y, hps_vx, hps_vy and hps_mass, all inputs, 32 bits each: the initial state values.
REQ-010 SHALL have ports hps_read_addr, input, m10k_address_len bits, and hps_x_out and hps_y_out, outputs, 32 bits each: the position readback port.
REQ-011 SHALL have port accel_addr, output, m10k_address_len bits: the acceleration read address sent to the force stage.
REQ-012 SHALL have ports x_accel_in and y_accel_in, inputs, 32 bits each: the acceleration read data, valid 1 cycle after accel_addr.
REQ-013 SHALL have ports pos_write_addr, output, m10k_address_len bits, and pos_we, output, 1 bit: the position write-back to the force stage.
REQ-014 SHALL have ports x_pos_out, y_pos_out and mass_out, outputs, 32 bits each: the write-back data.
REQ-015 SHALL have ports busy and done, outputs, 1 bit each: step in progress, and a one-cycle step-complete pulse.

Function
REQ-016 SHALL hold x, y, vx, vy and mass per object in internal RAMs with 1-cycle read latency, max_size entries each.
REQ-017 SHALL treat all 32-bit state as signed Q16.16 fixed point; sums wrap in two's complement with no saturation.
REQ-018 SHALL use the FSM states IDLE, READ, WAIT, CALC, WRITE and DONE.
REQ-019 In IDLE, start=1 with num_objects!=0 SHALL clear index i to 0 and go to READ; start with num_objects==0 SHALL go directly to DONE.
REQ-020 READ SHALL drive accel_addr=i and the state RAM read address i, then go to WAIT.
REQ-021 WAIT SHALL register x_accel_in, y_accel_in and the state RAM outputs, then go to CALC.
REQ-022 CALC SHALL compute vx' = vx + (x_accel >>> dt_shift) and x' = x + (vx' >>> dt_shift), with the same for y; the shifts are arithmetic and the update is semi-implicit Euler.
REQ-023 WRITE SHALL store vx', vy', x' and y' at index i, and for exactly 1 cycle drive pos_we=1, pos_write_addr=i, x_pos_out=x', y_pos_out=y' and mass_out=mass[i].
REQ-024 After WRITE, if i==num_objects-1 the FSM SHALL go to DONE; otherwise it SHALL increment i and go to READ.
REQ-025 Each object SHALL take exactly 4 cycles, and done SHALL rise 4*N+1 cycles after the start edge.
REQ-026 DONE SHALL assert done for 1 cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 hps_we SHALL be ignored while busy=1; in IDLE it SHALL write all five values at hps_addr, and SHALL NOT drive pos_we.
REQ-030 hps_x_out and hps_y_out SHALL return the x and y at hps_read_addr 1 cycle later, in any state.
REQ-031 When hps_read_addr equals an address being written in the same cycle, the readback SHALL return the old data.
REQ-032 num_objects SHALL be sampled on the start edge; later changes SHALL NOT affect the current step.

Reset
REQ-033 Reset SHALL force the FSM to IDLE, i=0, busy=0, done=0, pos_we=0, and accel_addr, pos_write_addr, x_pos_out, y_pos_out and mass_out to 0.
REQ-034 Reset mid-step SHALL abandon the step without a done pulse; RAM contents SHALL be retained and not cleared.

Structure
REQ-035 Package gravsim_pkg SHALL hold the Q16.16 typedef (32-bit signed), the fraction-bit constant 16 and the FSM state enum.
REQ-036 The RAMs SHALL use one sub-module, m10k_ram: simple dual-port, registered read, parameterised width and depth, instantiated once per field.

Verification
REQ-037 Load obj0 with x=0, vx=0, then start with N=1, dt_shift=4, x_accel_in=0x0001_0000. The bench SHALL see pos_we at start+4 with x_pos_out=0x0000_0100, stored vx=0x0000_1000, and done at start+5.
REQ-038 Run N=3. The bench SHALL see pos_we on exactly 3 cycles with pos_write_addr 0,1,2 spaced 4 cycles apart, busy high for 13 cycles, and done on the single cycle 13 cycles after start.
REQ-039 Load x=0x7FFF_FF00, vx=0x0010_0000, then start with a=0 and dt_shift=0. The bench SHALL see x_pos_out=0x800F_FF00 (wrap).
REQ-040 Pulse start and hps_we mid-step. The bench SHALL see no restart, no RAM change, and a done count of 1.
REQ-041 Assert reset during the second object of N=4. The bench SHALL see busy=0 and pos_we=0 on the next cycle, and no done pulse.
REQ-042 Start with num_objects=0. The bench SHALL see done 1 cycle later and pos_we never asserted.
